load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU pipeline and a word-wide data cache.
// Handles B/H/W loads with sign or zero extension, word stores, and
// read-modify-write for byte and half stores. All outputs are registered.
// Optional build macro: LSU_TIMEOUT_EN adds a 10-bit cache wait watchdog.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        st_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic [31:0] c_addr_o,
  output logic [31:0] c_din_o,
  output logic        c_we_o,
  output logic        c_rreq_o,
  input  logic [31:0] c_dout_i,
  input  logic        c_rdy_i
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 10;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          st_q, st_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] c_addr_q, c_addr_d;
  logic [DW-1:0] c_din_q, c_din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          c_we_q, c_we_d;
  logic          c_rreq_q, c_rreq_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          misalign_q, misalign_d;
  logic          timeout_q, timeout_d;
  logic          misalign_c;
  logic          timeout_hit_c;

  // Select the addressed lane of a cache word and extend it to 32 bits.
  function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] word,
                                                 input logic [1:0]    a,
                                                 input logic [2:0]    f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {a, 3'b000});
    h = 16'(word >> {a[1], 4'b0000});
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = word;
    endcase
  endfunction

  // Replace the addressed byte or half of a cache word with store data.
  function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] word,
                                                input logic [DW-1:0] wd,
                                                input logic [1:0]    a,
                                                input logic [2:0]    f3);
    logic [DW-1:0] mask;
    logic [DW-1:0] lane;
    if (f3[1:0] == 2'b00) begin
      mask = 32'h0000_00FF << {a, 3'b000};
      lane = 32'(wd[7:0]) << {a, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {a[1], 4'b0000};
      lane = 32'(wd[15:0]) << {a[1], 4'b0000};
    end
    store_merge = (word & ~mask) | (lane & mask);
  endfunction

  // Alignment check on the incoming request; unsupported width codes count as misaligned.
  always_comb begin
    misalign_c = 1'b1;
    case (funct3_i)
      3'b000, 3'b100: misalign_c = 1'b0;
      3'b001, 3'b101: misalign_c = addr_i[0];
      3'b010:         misalign_c = |addr_i[1:0];
      default:        misalign_c = 1'b1;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Watchdog counts cache wait cycles; restarts in each request state.
  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      RD_REQ, WR_REQ:   cnt_d = '0;
      RD_WAIT, WR_WAIT: cnt_d = cnt_q + CNT_W'(1);
      default:          cnt_d = cnt_q;
    endcase
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Fires on the wait cycle that would bring the count to 1023.
  assign timeout_hit_c = (cnt_q == CNT_W'(1022)) && !c_rdy_i;
`else
  assign timeout_hit_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    wdata_d    = wdata_q;
    c_addr_d   = c_addr_q;
    c_din_d    = c_din_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          st_d      = st_i;
          funct3_d  = funct3_i;
          addr_lo_d = addr_i[1:0];
          wdata_d   = wdata_i;
          c_addr_d  = {addr_i[31:2], 2'b00};
          if (misalign_c) begin
            state_d    = FIN;
            misalign_d = 1'b1;
            rdata_d    = '0;
          end else if (st_i && (funct3_i == 3'b010)) begin
            state_d = WR_REQ;
            c_din_d = wdata_i;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (c_rdy_i) begin
          if (st_q) begin
            state_d = WR_REQ;
            c_din_d = store_merge(c_dout_i, wdata_q, addr_lo_q, funct3_q);
          end else begin
            state_d = FIN;
            rdata_d = load_extract(c_dout_i, addr_lo_q, funct3_q);
          end
        end else if (timeout_hit_c) begin
          state_d   = FIN;
          timeout_d = 1'b1;
          rdata_d   = '0;
        end
      end
      WR_REQ: state_d = WR_WAIT;
      WR_WAIT: begin
        if (c_rdy_i) begin
          state_d = FIN;
        end else if (timeout_hit_c) begin
          state_d   = FIN;
          timeout_d = 1'b1;
          rdata_d   = '0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    c_rreq_d = (state_d == RD_REQ);
    c_we_d   = (state_d == WR_REQ);
    done_d   = (state_d == FIN);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      st_q       <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      wdata_q    <= '0;
      c_addr_q   <= '0;
      c_din_q    <= '0;
      rdata_q    <= '0;
      c_we_q     <= 1'b0;
      c_rreq_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      wdata_q    <= wdata_d;
      c_addr_q   <= c_addr_d;
      c_din_q    <= c_din_d;
      rdata_q    <= rdata_d;
      c_we_q     <= c_we_d;
      c_rreq_q   <= c_rreq_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
  assign misalign_o = misalign_q;
  assign timeout_o  = timeout_q;
  assign c_addr_o   = c_addr_q;
  assign c_din_o    = c_din_q;
  assign c_we_o     = c_we_q;
  assign c_rreq_o   = c_rreq_q;

endmodule
